// File: rtl/if_ctrl_pkg.sv
// Shared types for the instruction-fetch sequencing controller.
// Holds the FSM state encoding and the address width.
package if_ctrl_pkg;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    BOOT     = 2'b00,
    RUN      = 2'b01,
    REDIRECT = 2'b10,
    HALT     = 2'b11
  } fetch_state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the fetch performance counters.
// It sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: boot hold, load-use stall, branch redirect
// with flush, and halt/resume, plus stall/redirect perf counters.
module fetch_ctrl
  import if_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard,
  input  logic              exBrTaken,
  input  logic [ADDR_W-1:0] exBrOffset,
  input  logic              halt,
  input  logic              resume,
  output logic              freeze,
  output logic              brTaken,
  output logic [ADDR_W-1:0] brOffset,
  output logic              flushIFID,
  output logic              flushIDEX,
  output logic              fetchValid,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stallCount,
  output logic [CNT_W-1:0]  redirectCount
);
  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

  fetch_state_t  state_q, state_d;
  logic [BW-1:0] boot_cnt;
  logic          stall_inc;
  logic          redir_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= BOOT;
    else
      state_q <= state_d;
  end

  // Counts edges spent in BOOT; cleared on leaving so a re-boot starts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      boot_cnt <= '0;
    else if (state_q == BOOT && boot_cnt != BOOT_LAST)
      boot_cnt <= boot_cnt + BW'(1);
    else
      boot_cnt <= '0;
  end

  always_comb begin
    state_d    = state_q;
    freeze     = 1'b0;
    fetchValid = 1'b0;
    brTaken    = 1'b0;
    brOffset   = '0;
    flushIFID  = 1'b0;
    flushIDEX  = 1'b0;
    stall_inc  = 1'b0;
    redir_inc  = 1'b0;
    unique case (state_q)
      BOOT: begin
        freeze = 1'b1;
        if (boot_cnt == BOOT_LAST)
          state_d = RUN;
      end
      RUN: begin
        if (exBrTaken) begin
          brTaken   = 1'b1;
          brOffset  = exBrOffset;
          flushIFID = 1'b1;
          flushIDEX = 1'b1;
          redir_inc = 1'b1;
          state_d   = REDIRECT;
        end else begin
          // A halt request still honours this cycle's hazard stall.
          if (halt)
            state_d = HALT;
          if (hazard) begin
            freeze    = 1'b1;
            flushIDEX = 1'b1;
            stall_inc = 1'b1;
          end else begin
            fetchValid = 1'b1;
          end
        end
      end
      REDIRECT: begin
        fetchValid = 1'b1;
        state_d    = RUN;
      end
      HALT: begin
        freeze = 1'b1;
        if (resume)
          state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  assign state = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stallCount)
  );

  sat_counter #(.W(CNT_W)) u_redir_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redir_inc),
    .count (redirectCount)
  );
endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl against a cycle-level behavioural model.
// A second instance with 4-bit counters exercises saturation.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst, hazard, exBrTaken, halt, resume;
  logic [31:0] exBrOffset;

  logic        freeze, brTaken, flushIFID, flushIDEX, fetchValid;
  logic [31:0] brOffset;
  logic [1:0]  state;
  logic [15:0] stallCount, redirectCount;

  logic        s_freeze, s_brTaken, s_flushIFID, s_flushIDEX, s_fetchValid;
  logic [31:0] s_brOffset;
  logic [1:0]  s_state;
  logic [3:0]  s_stallCount, s_redirectCount;

  int checks   = 0;
  int failures = 0;

  // Model: mode 0=boot 1=run 2=redirect 3=halt (the debug encoding).
  int m_mode, m_edges, m_stalls, m_redirs;

  always #5 clk = ~clk;

  fetch_ctrl #(.BOOT_CYCLES(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .hazard(hazard), .exBrTaken(exBrTaken),
    .exBrOffset(exBrOffset), .halt(halt), .resume(resume),
    .freeze(freeze), .brTaken(brTaken), .brOffset(brOffset),
    .flushIFID(flushIFID), .flushIDEX(flushIDEX),
    .fetchValid(fetchValid), .state(state),
    .stallCount(stallCount), .redirectCount(redirectCount)
  );

  fetch_ctrl #(.BOOT_CYCLES(2), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .hazard(hazard), .exBrTaken(exBrTaken),
    .exBrOffset(exBrOffset), .halt(halt), .resume(resume),
    .freeze(s_freeze), .brTaken(s_brTaken), .brOffset(s_brOffset),
    .flushIFID(s_flushIFID), .flushIDEX(s_flushIDEX),
    .fetchValid(s_fetchValid), .state(s_state),
    .stallCount(s_stallCount), .redirectCount(s_redirectCount)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(int v, int w);
    int top;
    top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  task automatic model_reset();
    m_mode   = 0;
    m_edges  = 0;
    m_stalls = 0;
    m_redirs = 0;
  endtask

  task automatic check_outputs();
    logic        e_frz, e_val, e_br, e_fi, e_fx;
    logic [31:0] e_off;
    e_frz = 0; e_val = 0; e_br = 0; e_fi = 0; e_fx = 0; e_off = 0;
    case (m_mode)
      0: e_frz = 1;
      1: begin
        if (exBrTaken) begin
          e_br = 1; e_off = exBrOffset; e_fi = 1; e_fx = 1;
        end else if (hazard) begin
          e_frz = 1; e_fx = 1;
        end else begin
          e_val = 1;
        end
      end
      2: e_val = 1;
      default: e_frz = 1;
    endcase
    chk("freeze", 32'(freeze), 32'(e_frz));
    chk("fetchValid", 32'(fetchValid), 32'(e_val));
    chk("brTaken", 32'(brTaken), 32'(e_br));
    chk("brOffset", brOffset, e_off);
    chk("flushIFID", 32'(flushIFID), 32'(e_fi));
    chk("flushIDEX", 32'(flushIDEX), 32'(e_fx));
    chk("state", 32'(state), 32'(m_mode));
    chk("stallCount", 32'(stallCount), 32'(sat(m_stalls, 16)));
    chk("redirectCount", 32'(redirectCount), 32'(sat(m_redirs, 16)));
    chk("sat_state", 32'(s_state), 32'(m_mode));
    chk("sat_freeze", 32'(s_freeze), 32'(e_frz));
    chk("sat_stallCount", 32'(s_stallCount), 32'(sat(m_stalls, 4)));
    chk("sat_redirectCount", 32'(s_redirectCount), 32'(sat(m_redirs, 4)));
  endtask

  task automatic advance();
    if (rst) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: begin
        m_edges++;
        if (m_edges >= 2) m_mode = 1;
      end
      1: begin
        if (exBrTaken) begin
          m_redirs++;
          m_mode = 2;
        end else begin
          if (hazard) m_stalls++;
          if (halt) m_mode = 3;
        end
      end
      2: m_mode = 1;
      default: if (resume) m_mode = 1;
    endcase
  endtask

  // Called at posedge+1: drive, check mid-cycle, then clock the model.
  task automatic cycle(bit r, bit h, bit b, logic [31:0] o, bit ha, bit re);
    rst = r; hazard = h; exBrTaken = b; exBrOffset = o;
    halt = ha; resume = re;
    #3;
    if (rst) model_reset();
    check_outputs();
    @(posedge clk);
    advance();
    #1;
  endtask

  initial begin
    rst = 1; hazard = 0; exBrTaken = 0; exBrOffset = 0;
    halt = 0; resume = 0;
    model_reset();
    #1;

    // Reset held 3 cycles, then boot with ignored random inputs.
    repeat (3) cycle(1, 1, 1, $urandom, 1, 1);
    chk("reset_freeze", 32'(freeze), 32'd1);
    repeat (2) cycle(0, 1'($urandom), 1'($urandom), $urandom,
                     1'($urandom), 1'($urandom));
    chk("boot_exit_state", 32'(state), 32'd1);

    repeat (3) cycle(0, 1, 0, 0, 0, 0);
    chk("stall3", 32'(stallCount), 32'd3);

    cycle(0, 1, 1, 32'h10, 0, 0);
    chk("redirect_state", 32'(state), 32'd2);
    cycle(0, 1, 1, 32'h20, 1, 0);
    chk("redir_once", 32'(redirectCount), 32'd1);
    chk("stall_kept", 32'(stallCount), 32'd3);

    cycle(0, 0, 0, 0, 1, 0);
    chk("halt_state", 32'(state), 32'd3);
    repeat (3) cycle(0, 1, 1, 32'h44, 1, 0);
    cycle(0, 0, 0, 0, 0, 1);
    chk("resume_state", 32'(state), 32'd1);

    repeat (20) cycle(0, 1, 0, 0, 0, 0);
    chk("sat4_stall", 32'(s_stallCount), 32'd15);
    chk("full_stall", 32'(stallCount), 32'd23);

    // Asynchronous reset between edges while halted.
    cycle(0, 0, 0, 0, 1, 0);
    hazard = 0; exBrTaken = 0; halt = 0; resume = 0;
    #2 rst = 1;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_freeze", 32'(freeze), 32'd1);
    chk("async_stall", 32'(stallCount), 32'd0);
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    repeat (2) cycle(1, 0, 0, 0, 0, 0);
    repeat (2) cycle(0, 1, 1, 32'h8, 0, 0);
    chk("reboot_state", 32'(state), 32'd1);

    repeat (3000)
      cycle($urandom_range(0, 99) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0,
            $urandom,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
